// File: rtl/shift_reg_param_if.sv
// Bus bundle for shift_reg_param: the control strobes, the serial and parallel data, and the status.
// Ports: the master drives load, parallel_in, shift_en, dir, rotate, serial_in, burst_start and burst_len;
//        the slave drives serial_out, reg_content, busy and done.
interface shift_reg_param_if #(
  parameter int WIDTH = 8
);
  localparam int LW = $clog2(WIDTH + 1);

  logic             load;
  logic [WIDTH-1:0] parallel_in;
  logic             shift_en;
  logic             dir;
  logic             rotate;
  logic             serial_in;
  logic             burst_start;
  logic [LW-1:0]    burst_len;
  logic             serial_out;
  logic [WIDTH-1:0] reg_content;
  logic             busy;
  logic             done;

  modport master (
    output load, parallel_in, shift_en, dir, rotate, serial_in, burst_start, burst_len,
    input  serial_out, reg_content, busy, done
  );

  modport slave (
    input  load, parallel_in, shift_en, dir, rotate, serial_in, burst_start, burst_len,
    output serial_out, reg_content, busy, done
  );
endinterface

// File: rtl/shift_reg_param.sv
// Universal WIDTH-bit shift register: parallel load, left/right shift or rotate, and autonomous bursts.
// Latency: load and single shifts land on the capturing edge; a burst of L shifts occupies edges 1..L, with done after that.
// Backpressure: none; while busy, single-step and new-burst requests are dropped, and only load can interrupt.
// Ports: clk and reset_n (asynchronous, active-low) are plain ports; everything else travels on bus (slave modport).
module shift_reg_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  shift_reg_param_if.slave   bus
);
  localparam int LW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [LW-1:0]    cnt;
  logic [WIDTH-1:0] data;
  logic             burst_dir;
  logic             burst_rot;

  logic             eff_dir;
  logic             eff_rot;
  logic             out_bit;
  logic             in_bit;
  logic [WIDTH-1:0] shifted;
  logic [LW-1:0]    len_clamped;

  // A running burst keeps the direction and mode it captured at its start, so the live inputs are free to change underneath it.
  assign eff_dir = (state == ST_SHIFT) ? burst_dir : bus.dir;
  assign eff_rot = (state == ST_SHIFT) ? burst_rot : bus.rotate;

  // out_bit is the bit that the next shift discards. In rotate mode it is fed back in at the other end.
  assign out_bit = eff_dir ? data[0] : data[WIDTH-1];
  assign in_bit  = eff_rot ? out_bit : bus.serial_in;
  assign shifted = eff_dir ? {in_bit, data[WIDTH-1:1]} : {data[WIDTH-2:0], in_bit};

  assign len_clamped = (bus.burst_len > LW'(WIDTH)) ? LW'(WIDTH) : bus.burst_len;

  assign bus.serial_out  = out_bit;
  assign bus.reg_content = data;
  assign bus.busy        = (state == ST_SHIFT);
  assign bus.done        = (state == ST_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      data      <= '0;
      burst_dir <= 1'b0;
      burst_rot <= 1'b0;
    end else if (bus.load) begin
      // A load aborts any burst in progress and suppresses its done pulse.
      data  <= bus.parallel_in;
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.burst_start) begin
            // The start edge only arms the burst. The first shift happens on the following edge.
            burst_dir <= bus.dir;
            burst_rot <= bus.rotate;
            cnt       <= len_clamped;
            state     <= (len_clamped != '0) ? ST_SHIFT : ST_DONE;
          end else begin
            if (state == ST_IDLE && bus.shift_en) begin
              data <= shifted;
            end
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          data <= shifted;
          cnt  <= cnt - LW'(1);
          if (cnt == LW'(1)) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_reg_param.sv
module tb_shift_reg_param;
  localparam int WIDTH = 8;
  localparam int LW    = $clog2(WIDTH + 1);

  logic clk;
  logic reset_n;
  int   cmp_cnt;
  int   err_cnt;

  shift_reg_param_if #(.WIDTH(WIDTH)) bus();

  shift_reg_param #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] pin;
    logic       sh;
    logic       dir;
    logic       rot;
    logic       sin;
    logic       so;   // serial_out expected before the edge
    logic [7:0] q;    // reg_content expected after the edge
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load        = 1'b0;
    bus.parallel_in = '0;
    bus.shift_en    = 1'b0;
    bus.dir         = 1'b0;
    bus.rotate      = 1'b0;
    bus.serial_in   = 1'b0;
    bus.burst_start = 1'b0;
    bus.burst_len   = '0;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load        = 1'b1;
    bus.parallel_in = v;
    step();
    bus.load        = 1'b0;
  endtask

  task automatic start_burst(input logic [LW-1:0] len, input logic d, input logic r, input logic s);
    bus.burst_start = 1'b1;
    bus.burst_len   = len;
    bus.dir         = d;
    bus.rotate      = r;
    bus.serial_in   = s;
    step();
    bus.burst_start = 1'b0;
  endtask

  initial begin
    logic [7:0] ser_exp;
    int         busy_cycles;

    cmp_cnt = 0;
    err_cnt = 0;
    idle_inputs();
    reset_n = 1'b0;
    #12;
    check("reset_reg", bus.reg_content, 8'h00);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_so", bus.serial_out, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Single-step vectors:           ld    pin    sh    dir   rot   sin   so    q
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h4B};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h25};
    vecs[3] = '{1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC0};
    vecs[5] = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h06};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0C};
    vecs[9] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0C};

    for (int i = 0; i < 10; i++) begin
      bus.load        = vecs[i].ld;
      bus.parallel_in = vecs[i].pin;
      bus.shift_en    = vecs[i].sh;
      bus.dir         = vecs[i].dir;
      bus.rotate      = vecs[i].rot;
      bus.serial_in   = vecs[i].sin;
      #1;
      check($sformatf("vec%0d_so", i), bus.serial_out, vecs[i].so);
      step();
      check($sformatf("vec%0d_reg", i), bus.reg_content, vecs[i].q);
    end
    idle_inputs();

    // Serializer burst of 8 from 0xA5. Live dir and shift_en toggled during the burst must not matter.
    do_load(8'hA5);
    start_burst(4'd8, 1'b0, 1'b0, 1'b0);
    ser_exp = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ser_busy%0d", i), bus.busy, 1'b1);
      check($sformatf("ser_bit%0d", i), bus.serial_out, ser_exp[7 - i]);
      bus.shift_en = 1'b1;
      bus.dir      = 1'b1;
      step();
    end
    bus.shift_en = 1'b0;
    bus.dir      = 1'b0;
    check("ser_done", bus.done, 1'b1);
    check("ser_busy_end", bus.busy, 1'b0);
    check("ser_reg", bus.reg_content, 8'h00);
    step();
    check("ser_done_clr", bus.done, 1'b0);

    // A load on the third busy cycle aborts the burst, and no done pulse follows.
    do_load(8'hFF);
    start_burst(4'd8, 1'b0, 1'b0, 1'b0);
    step();
    step();
    bus.load        = 1'b1;
    bus.parallel_in = 8'h3C;
    step();
    bus.load        = 1'b0;
    check("abort_reg", bus.reg_content, 8'h3C);
    check("abort_busy", bus.busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_nodone%0d", i), bus.done, 1'b0);
      step();
    end

    // A zero-length burst goes straight to done, with no shift and no busy.
    do_load(8'h5A);
    start_burst(4'd0, 1'b0, 1'b0, 1'b1);
    check("len0_done", bus.done, 1'b1);
    check("len0_busy", bus.busy, 1'b0);
    check("len0_reg", bus.reg_content, 8'h5A);
    step();
    check("len0_done_clr", bus.done, 1'b0);

    // burst_len=12 is clamped to 8 rotations, so 0x01 returns to 0x01 (12 rotations would give 0x10).
    do_load(8'h01);
    start_burst(4'd12, 1'b0, 1'b1, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      busy_cycles++;
      step();
    end
    check("clamp_busy_cycles", busy_cycles, 8);
    check("clamp_done", bus.done, 1'b1);
    check("clamp_reg", bus.reg_content, 8'h01);
    // Start another burst in the done cycle: right shifts with serial_in=1, with no idle gap.
    start_burst(4'd2, 1'b1, 1'b0, 1'b1);
    check("b2b_busy", bus.busy, 1'b1);
    check("b2b_done", bus.done, 1'b0);
    step();
    step();
    check("b2b_done_end", bus.done, 1'b1);
    check("b2b_reg", bus.reg_content, 8'hC0);
    step();

    // Asynchronous reset in the middle of a burst, asserted away from any clock edge.
    do_load(8'hA5);
    start_burst(4'd8, 1'b0, 1'b0, 1'b1);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_reg", bus.reg_content, 8'h00);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_so", bus.serial_out, 1'b0);
    step();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("arst_nodone%0d", i), bus.done, 1'b0);
      check($sformatf("arst_idle%0d", i), bus.busy, 1'b0);
    end
    check("arst_reg_after", bus.reg_content, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", cmp_cnt);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_reg_param.md
# shift_reg_param

Parametrised universal shift register: the next generation of the practical-1 parallel/serial register. Generalised to WIDTH bits, with left/right shift, rotate, and an autonomous burst mode that shifts a programmed number of bits and flags completion. Sits between a parallel datapath and a serial link, used as both serializer and deserializer. Unlike the previous register, the contents and serial output are always live, not updated only on hold cycles.

## Interface
- WIDTH, 8, register width in bits (≥2)
- LW, $clog2(WIDTH+1), width of burst_len (derived, do not override)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  parallel load strobe (highest priority)
- parallel_in  in  WIDTH  data for load
- shift_en  in  1  single-step shift in idle
- dir  in  1  0 = left (MSB out, serial_in into LSB), 1 = right (LSB out, serial_in into MSB)
- rotate  in  1  1 = shifted-out bit re-enters the other end; serial_in ignored
- serial_in  in  1  serial data input
- burst_start  in  1  begin burst of burst_len shifts
- burst_len  in  LW  number of shifts in a burst
- serial_out  out  1  bit that the next shift will discard (combinational from register and effective dir)
- reg_content  out  WIDTH  live register value
- busy  out  1  high while burst shifting
- done  out  1  one-cycle pulse when a burst completes

## Operation
- Reset: register 0, state IDLE, counter 0, busy 0, done 0; serial_out 0 (follows register).
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE).
- Priority per edge: load > burst_start > shift_en.
- load (any state): register <= parallel_in; state -> IDLE; any burst aborted, no done pulse.
- IDLE or DONE, burst_start=1: latch dir/rotate into burst_dir/burst_rot; counter <= min(burst_len, WIDTH); state -> SHIFT if counter value ≥1, else DONE. No shift on this edge.
- SHIFT: each edge shift once with latched dir/rotate (live serial_in); counter decrements; at the edge where counter goes 1 -> 0 state -> DONE. dir, rotate, shift_en, burst_start ignored.
- DONE: one cycle, then IDLE unless load or burst_start (both accepted in DONE, back-to-back bursts allowed).
- IDLE, shift_en=1 (no load/burst_start): one shift using live dir/rotate; state unchanged.
- Shift left: reg <= {reg[WIDTH-2:0], in}; right: reg <= {in, reg[WIDTH-1:1]}; in = rotate ? outgoing bit : serial_in.
- Effective dir for serial_out: burst_dir in SHIFT, else live dir.
- burst_len > WIDTH clamped to WIDTH.

## Timing
- load/shift: reg_content updated at the capturing edge, visible same cycle after it; latency 1.
- Burst of L≥1 accepted at edge 0: shifts at edges 1..L; busy high after edge 0 through edge L; done high for the cycle after edge L; IDLE after edge L+1.
- L=0: done high for the cycle after edge 0, no shift, busy never asserted.
- Serializer: serial_out sampled before each edge 1..L gives bits in shift order.
- reset_n low at any time: immediate return to reset values, no clock needed; burst abandoned, no done.

## Test plan
- WIDTH=8; reset_n low mid-burst -> reg_content=0x00, busy=0, done=0 asynchronously; after release IDLE, no spurious done.
- load 0xA5; shift_en, dir=0, serial_in=1 -> serial_out=1 before edge, reg_content=0x4B; then dir=1, serial_in=0 -> 0x25.
- load 0x81; dir=1, rotate=1, shift_en -> 0xC0; dir=0 rotate twice from 0x81 -> 0x06.
- load 0xA5; burst_start, burst_len=8, dir=0, serial_in=0 -> serial_out 1,0,1,0,0,1,0,1 across 8 shifts, busy 8 cycles, done one cycle after, reg_content=0x00; shift_en during busy has no effect.
- Burst 8 left from 0xFF; load 0x3C at third busy cycle -> reg_content=0x3C, busy=0, done never pulses.
- burst_len=0 -> done next cycle, reg unchanged, busy never high; burst_len=12 -> exactly 8 shifts; burst_start in DONE cycle -> second burst starts without IDLE gap.
